// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: FSM states, default
// memory base and destination width, and the address translation helper.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [31:0] MEM_BASE = 32'd1024;
  localparam int          DEST_W   = 5;

  // Rebase the ALU result onto the data memory and force word alignment.
  // The subtraction wraps modulo 2^32 on purpose, so results below the
  // base simply land at the top of the address space.
  function automatic logic [31:0] word_addr(input logic [31:0] alu_result,
                                            input logic [31:0] base);
    logic [31:0] rebased;
    rebased = alu_result - base;
    return {rebased[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble kills the write-back and load flags
// while leaving the data fields as they were.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DEST_W = mem_stage_pkg::DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bubble,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       MEM_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_read_value,
  output logic [DEST_W-1:0] Dest
);

  // Load the next instruction, insert a bubble, or clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_en          <= 1'b0;
      MEM_R_EN       <= 1'b0;
      ALU_result     <= 32'd0;
      MEM_read_value <= 32'd0;
      Dest           <= '0;
    end else if (bubble) begin
      WB_en    <= 1'b0;
      MEM_R_EN <= 1'b0;
    end else begin
      WB_en          <= WB_en_in;
      MEM_R_EN       <= MEM_R_EN_in;
      ALU_result     <= ALU_result_in;
      MEM_read_value <= MEM_read_value_in;
      Dest           <= Dest_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues a registered request for loads and stores, stalls
// the front of the pipeline until the memory acknowledges, then hands the
// instruction and any loaded data to the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = mem_stage_pkg::MEM_BASE,
  parameter int          DEST_W   = mem_stage_pkg::DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              freeze,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_read_value,
  output logic [DEST_W-1:0] Dest
);

  mem_state_t  state;
  logic [31:0] rdata_q;
  logic        mem_access;

  assign mem_access = MEM_R_EN_in | MEM_W_EN_in;

  // Stall upstream as soon as a memory instruction shows up and until the ack.
  always_comb begin
    freeze = 1'b0;
    case (state)
      IDLE:    freeze = mem_access;
      WAIT:    freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
  end

  // Request FSM: IDLE issues, WAIT holds the request until ack, DONE releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_access) begin
            mem_req   <= 1'b1;
            mem_we    <= MEM_W_EN_in;
            mem_addr  <= word_addr(ALU_result_in, MEM_BASE);
            mem_wdata <= ST_val_in;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              rdata_q <= mem_rdata;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  mem_wb_reg #(
    .DEST_W(DEST_W)
  ) u_mem_wb_reg (
    .clk               (clk),
    .rst               (rst),
    .bubble            (freeze),
    .WB_en_in          (WB_en_in),
    .MEM_R_EN_in       (MEM_R_EN_in),
    .ALU_result_in     (ALU_result_in),
    .MEM_read_value_in (rdata_q),
    .Dest_in           (Dest_in),
    .WB_en             (WB_en),
    .MEM_R_EN          (MEM_R_EN),
    .ALU_result        (ALU_result),
    .MEM_read_value    (MEM_read_value),
    .Dest              (Dest)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU passthrough, store, load,
// back-to-back loads, address wrap, read+write priority and reset in WAIT.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, ST_val_in;
  logic [4:0]  Dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic        WB_en, MEM_R_EN;
  logic [31:0] ALU_result, MEM_read_value;
  logic [4:0]  Dest;
  logic [70:0] wb_bus;

  int vectors = 0;
  int miscompares = 0;

  assign wb_bus = {WB_en, MEM_R_EN, ALU_result, MEM_read_value, Dest};

  mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .WB_en_in       (WB_en_in),
    .MEM_R_EN_in    (MEM_R_EN_in),
    .MEM_W_EN_in    (MEM_W_EN_in),
    .ALU_result_in  (ALU_result_in),
    .ST_val_in      (ST_val_in),
    .Dest_in        (Dest_in),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .freeze         (freeze),
    .WB_en          (WB_en),
    .MEM_R_EN       (MEM_R_EN),
    .ALU_result     (ALU_result),
    .MEM_read_value (MEM_read_value),
    .Dest           (Dest)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic wb, input logic rd, input logic wr,
                            input logic [31:0] alu, input logic [31:0] st,
                            input logic [4:0] dst);
    WB_en_in      = wb;
    MEM_R_EN_in   = rd;
    MEM_W_EN_in   = wr;
    ALU_result_in = alu;
    ST_val_in     = st;
    Dest_in       = dst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_req: got %b want 0", mem_req); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b want 0", mem_we); end
    vectors++; if (wb_bus !== 71'd0) begin miscompares++; $display("[TB] FAIL reset_mem_wb: got %h want 0", wb_bus); end
    rst = 1'b0;
    #1;
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_freeze: got %b want 0", freeze); end
  endtask

  task automatic test_alu_op();
    set_inputs(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 5'd3);
    #1;
    vectors++; if (freeze !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_freeze_now: got %b want 0", freeze); end
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b0, 32'h55, 32'h0, 5'd3}) begin miscompares++; $display("[TB] FAIL alu_mem_wb: got %h want %h", wb_bus, {1'b1, 1'b0, 32'h55, 32'h0, 5'd3}); end
    vectors++; if ({freeze, mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL alu_no_stall: got %b want 00", {freeze, mem_req}); end
  endtask

  task automatic test_store();
    int fcount;
    fcount = 0;
    set_inputs(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD, 5'd7);
    #1;
    if (freeze === 1'b1) fcount++;
    vectors++; if ({freeze, mem_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL store_c0_freeze_req: got %b want 10", {freeze, mem_req}); end
    tick();
    if (freeze === 1'b1) fcount++;
    vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'd4, 32'hDEAD}) begin miscompares++; $display("[TB] FAIL store_request: got %h want %h", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'd4, 32'hDEAD}); end
    vectors++; if (wb_bus !== {1'b0, 1'b0, 32'h55, 32'h0, 5'd3}) begin miscompares++; $display("[TB] FAIL store_bubble: got %h want %h", wb_bus, {1'b0, 1'b0, 32'h55, 32'h0, 5'd3}); end
    tick();
    if (freeze === 1'b1) fcount++;
    vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'd4, 32'hDEAD}) begin miscompares++; $display("[TB] FAIL store_request_stable: got %h want %h", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'd4, 32'hDEAD}); end
    mem_ack = 1'b1;
    tick();
    // Ack is left high through DONE, where it must be ignored.
    if (freeze === 1'b1) fcount++;
    vectors++; if ({freeze, mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL store_done: got %b want 00", {freeze, mem_req}); end
    vectors++; if (fcount !== 3) begin miscompares++; $display("[TB] FAIL store_freeze_cycles: got %0d want 3", fcount); end
    tick();
    mem_ack = 1'b0;
    vectors++; if (wb_bus !== {1'b0, 1'b0, 32'd1028, 32'h0, 5'd7}) begin miscompares++; $display("[TB] FAIL store_writeback: got %h want %h", wb_bus, {1'b0, 1'b0, 32'd1028, 32'h0, 5'd7}); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL store_no_reissue: got %b want 0", mem_req); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_load();
    set_inputs(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 5'd9);
    #1;
    vectors++; if (freeze !== 1'b1) begin miscompares++; $display("[TB] FAIL load_freeze: got %b want 1", freeze); end
    tick();
    vectors++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'd8}) begin miscompares++; $display("[TB] FAIL load_request: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'd8}); end
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h1234;
    vectors++; if ({freeze, mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL load_done: got %b want 00", {freeze, mem_req}); end
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b1, 32'd1032, 32'hCAFE, 5'd9}) begin miscompares++; $display("[TB] FAIL load_writeback: got %h want %h", wb_bus, {1'b1, 1'b1, 32'd1032, 32'hCAFE, 5'd9}); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_back_to_back();
    set_inputs(1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 5'd10);
    tick();
    vectors++; if ({mem_req, mem_addr} !== {1'b1, 32'h10}) begin miscompares++; $display("[TB] FAIL b2b_first_req: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h10}); end
    mem_ack = 1'b1;
    mem_rdata = 32'h1111;
    tick();
    mem_ack = 1'b0;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_req: got %b want 0", mem_req); end
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b1, 32'd1040, 32'h1111, 5'd10}) begin miscompares++; $display("[TB] FAIL b2b_first_wb: got %h want %h", wb_bus, {1'b1, 1'b1, 32'd1040, 32'h1111, 5'd10}); end
    set_inputs(1'b1, 1'b1, 1'b0, 32'd1044, 32'd0, 5'd11);
    #1;
    vectors++; if ({freeze, mem_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL b2b_second_issue: got %b want 10", {freeze, mem_req}); end
    tick();
    vectors++; if ({mem_req, mem_addr} !== {1'b1, 32'h14}) begin miscompares++; $display("[TB] FAIL b2b_second_req: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h14}); end
    vectors++; if (wb_bus !== {1'b0, 1'b0, 32'd1040, 32'h1111, 5'd10}) begin miscompares++; $display("[TB] FAIL b2b_bubble: got %h want %h", wb_bus, {1'b0, 1'b0, 32'd1040, 32'h1111, 5'd10}); end
    mem_ack = 1'b1;
    mem_rdata = 32'h2222;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b1, 32'd1044, 32'h2222, 5'd11}) begin miscompares++; $display("[TB] FAIL b2b_second_wb: got %h want %h", wb_bus, {1'b1, 1'b1, 32'd1044, 32'h2222, 5'd11}); end
    set_inputs(1'b1, 1'b0, 1'b0, 32'h77, 32'd0, 5'd4);
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b0, 32'h77, 32'h2222, 5'd4}) begin miscompares++; $display("[TB] FAIL hold_read_value: got %h want %h", wb_bus, {1'b1, 1'b0, 32'h77, 32'h2222, 5'd4}); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_wrap_and_priority();
    set_inputs(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd1);
    tick();
    vectors++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'hFFFFFC00}) begin miscompares++; $display("[TB] FAIL wrap_request: got %h want %h", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'hFFFFFC00}); end
    mem_ack = 1'b1;
    mem_rdata = 32'hBEEF;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++; if (wb_bus !== {1'b1, 1'b1, 32'd0, 32'hBEEF, 5'd1}) begin miscompares++; $display("[TB] FAIL wrap_writeback: got %h want %h", wb_bus, {1'b1, 1'b1, 32'd0, 32'hBEEF, 5'd1}); end
    // Read and write both set behaves as a write; the misaligned low bits drop.
    set_inputs(1'b0, 1'b1, 1'b1, 32'd1027, 32'd5, 5'd2);
    tick();
    vectors++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'd0, 32'd5}) begin miscompares++; $display("[TB] FAIL rw_as_write: got %h want %h", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 32'd0, 32'd5}); end
    mem_ack = 1'b1;
    mem_rdata = 32'h9999;
    tick();
    mem_ack = 1'b0;
    tick();
    vectors++; if (wb_bus !== {1'b0, 1'b1, 32'd1027, 32'hBEEF, 5'd2}) begin miscompares++; $display("[TB] FAIL rw_no_capture: got %h want %h", wb_bus, {1'b0, 1'b1, 32'd1027, 32'hBEEF, 5'd2}); end
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic test_reset_in_wait();
    set_inputs(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 5'd5);
    tick();
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rstwait_req: got %b want 1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    #1;
    vectors++; if ({freeze, mem_req, mem_we} !== 3'b000) begin miscompares++; $display("[TB] FAIL rstwait_ctrl: got %b want 000", {freeze, mem_req, mem_we}); end
    vectors++; if (wb_bus !== 71'd0) begin miscompares++; $display("[TB] FAIL rstwait_mem_wb: got %h want 0", wb_bus); end
    mem_ack = 1'b1;
    mem_rdata = 32'hAAAA;
    tick();
    mem_ack = 1'b0;
    vectors++; if ({freeze, mem_req} !== 2'b00) begin miscompares++; $display("[TB] FAIL late_ack_ctrl: got %b want 00", {freeze, mem_req}); end
    tick();
    vectors++; if (wb_bus !== 71'd0) begin miscompares++; $display("[TB] FAIL late_ack_mem_wb: got %h want 0", wb_bus); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] mem_stage directed test start");
    test_reset();
    test_alu_op();
    test_store();
    test_load();
    test_back_to_back();
    test_wrap_and_priority();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MEM_BASE, default 32'd1024: data-memory base subtracted from the ALU result.
REQ-002 Parameter DEST_W, default 5: destination register index width.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 WB_en_in, MEM_R_EN_in, MEM_W_EN_in  in  1 each  control bits from the EXE/MEM register.
REQ-006 ALU_result_in  in  32  address for loads/stores, or the passthrough result.
REQ-007 ST_val_in  in  32  store data.
REQ-008 Dest_in  in  DEST_W  destination register index.
REQ-009 mem_req  out  1  memory request, registered.
REQ-010 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-011 mem_addr  out  32  byte address = ALU_result_in - MEM_BASE, bits [1:0] forced to 0.
REQ-012 mem_wdata  out  32  store data; valid while mem_req=1.
REQ-013 mem_ack  in  1  single-cycle completion pulse from memory.
REQ-014 mem_rdata  in  32  read data, valid in the mem_ack cycle.
REQ-015 freeze  out  1  combinational stall to the IF, ID and EXE pipeline registers.
REQ-016 WB_en, MEM_R_EN  out  1 each  MEM/WB register outputs.
REQ-017 ALU_result, MEM_read_value  out  32 each  MEM/WB register outputs.
REQ-018 Dest  out  DEST_W  MEM/WB register output.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-020 IDLE with MEM_R_EN_in=0 and MEM_W_EN_in=0 SHALL keep freeze=0 and load the inputs into the MEM/WB register at the next edge, giving 1-cycle latency.
REQ-021 IDLE with MEM_R_EN_in or MEM_W_EN_in set SHALL assert freeze=1 combinationally, set mem_req=1, set mem_we=MEM_W_EN_in, and move to WAIT.
REQ-022 If MEM_R_EN_in and MEM_W_EN_in are both 1, the access SHALL be treated as a write.
REQ-023 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable and freeze SHALL stay 1 until mem_ack=1.
REQ-024 On mem_ack in WAIT, the block SHALL capture mem_rdata (reads only), clear mem_req at the next edge, and move to DONE.
REQ-025 In DONE, freeze SHALL be 0 and the MEM/WB register SHALL load the held inputs plus the captured read data; the FSM SHALL then return to IDLE.
REQ-026 A memory access SHALL take at least 3 cycles: request, ack, DONE.
REQ-027 While freeze=1, the MEM/WB register SHALL load a bubble: WB_en=0, MEM_R_EN=0, other fields unchanged.
REQ-028 mem_ack outside WAIT SHALL be ignored.
REQ-029 mem_ack in the same cycle that mem_req first rises SHALL NOT be possible, because the request is registered.
REQ-030 mem_addr SHALL wrap modulo 2^32 when ALU_result_in < MEM_BASE; no fault is raised.
REQ-031 MEM_read_value SHALL hold its last captured value on non-load instructions.

Reset
REQ-032 rst SHALL force state=IDLE, mem_req=0, mem_we=0, and the captured read data to 0.
REQ-033 rst SHALL clear all MEM/WB outputs to 0, including Dest.
REQ-034 rst during WAIT SHALL abandon the access without waiting for mem_ack; a late ack SHALL be ignored.
REQ-035 freeze SHALL be 0 in the cycle following reset unless a memory instruction is already present at the inputs.

Structure
REQ-036 The shared pipeline package SHALL hold the FSM state enum (IDLE, WAIT, DONE), MEM_BASE, and DEST_W.
REQ-037 The MEM/WB register SHALL be a separate sub-module, mem_wb_reg, with clk, rst and a bubble input.
REQ-038 The FSM, address computation and read-data capture SHALL reside in mem_stage.

Verification
REQ-039 ALU op (WB_en_in=1, ALU_result_in=32'h55, Dest_in=3) -> next cycle WB_en=1, ALU_result=32'h55, Dest=3, freeze stays 0.
REQ-040 Store (ALU_result_in=1028, ST_val_in=32'hDEAD) with ack 2 cycles after the request -> mem_addr=4, mem_we=1, mem_wdata=32'hDEAD, freeze high 3 cycles, then WB_en=0.
REQ-041 Load (ALU_result_in=1032) with mem_rdata=32'hCAFE on ack -> mem_addr=8; after DONE, MEM_read_value=32'hCAFE, MEM_R_EN=1, and WB_en follows WB_en_in.
REQ-042 Two back-to-back loads -> second mem_req rises the cycle after DONE, and each Dest is written back in order.
REQ-043 rst asserted in WAIT, then a spurious mem_ack -> state IDLE, all outputs 0, and the ack produces no MEM/WB update.
REQ-044 ALU_result_in=0 with a load -> mem_addr=32'hFFFFFC00, and the access completes normally.
